ca_line_gen: RTL and testbench

- Parametrised successor to the CA generator and seed-line generator pair.
- Evolves one line of an elementary (1-D, 3-neighbour) cellular automaton per start pulse: streams the previous line out of a double-banked line RAM and writes the next line into the opposite bank.
- Also has a seed mode that writes a single-centre-pixel line, replacing the separate reset generator.
- Sits between the sync generator (start strobe in horizontal blanking) and the image RAM port shared with the line filler.

---
 rtl/ca_pkg.sv | 26 ++
 rtl/ca_rule_word.sv | 20 ++
 rtl/ca_line_gen.sv | 158 +++++++++++++++
 tb/tb_ca_line_gen.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/ca_pkg.sv
// rtl/ca_pkg.sv - shared state encoding, mode and rule constants for the CA line generator
package ca_pkg;

  localparam logic [2:0] ST_IDLE     = 3'd0;
  localparam logic [2:0] ST_PREFETCH = 3'd1;
  localparam logic [2:0] ST_STREAM   = 3'd2;
  localparam logic [2:0] ST_FLUSH    = 3'd3;
  localparam logic [2:0] ST_SEED     = 3'd4;
  localparam logic [2:0] ST_FIN      = 3'd5;

  typedef enum logic [2:0] {
    S_IDLE     = ST_IDLE,
    S_PREFETCH = ST_PREFETCH,
    S_STREAM   = ST_STREAM,
    S_FLUSH    = ST_FLUSH,
    S_SEED     = ST_SEED,
    S_FIN      = ST_FIN
  } state_t;

  localparam logic MODE_EVOLVE = 1'b0;
  localparam logic MODE_SEED   = 1'b1;

  localparam logic [7:0] RULE_90 = 8'd90;
  localparam logic [7:0] RULE_30 = 8'd30;

endpackage

// File: rtl/ca_rule_word.sv
// rtl/ca_rule_word.sv - applies an elementary CA rule to one word given its outer neighbour bits
module ca_rule_word #(
  parameter int WORD_W = 16
) (
  input  logic              i_left,
  input  logic [WORD_W-1:0] i_word,
  input  logic              i_right,
  input  logic [7:0]        i_rule,
  output logic [WORD_W-1:0] o_word
);

  // bit 0 is leftmost, so the left neighbour sits below each bit in w_ext
  logic [WORD_W+1:0] w_ext;
  assign w_ext = {i_right, i_word, i_left};

  for (genvar i = 0; i < WORD_W; i++) begin : g_cell
    assign o_word[i] = i_rule[{w_ext[i], w_ext[i+1], w_ext[i+2]}];
  end

endmodule

// File: rtl/ca_line_gen.sv
// rtl/ca_line_gen.sv - evolves or seeds one CA line between the two banks of a line RAM
// Build option CA_WRAP_EN: toroidal line edges; when undefined both edge neighbours are 0.
module ca_line_gen
  import ca_pkg::*;
#(
  parameter int WORD_W     = 16,
  parameter int LINE_WORDS = 64,
  parameter int ADDR_W     = 7
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              mode,
  input  logic [7:0]        rule,
  input  logic              direction,
  output logic              read,
  output logic [ADDR_W-1:0] raddr,
  input  logic [WORD_W-1:0] rdata,
  output logic              write,
  output logic [ADDR_W-1:0] waddr,
  output logic [WORD_W-1:0] wdata,
  output logic              busy,
  output logic              done
);

  localparam int IDX_W = ADDR_W - 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(LINE_WORDS - 1);
  localparam int SEED_PIX = LINE_WORDS * WORD_W / 2;
  localparam logic [IDX_W-1:0] SEED_IDX = IDX_W'(SEED_PIX / WORD_W);
  localparam logic [WORD_W-1:0] SEED_BIT = WORD_W'(1) << (SEED_PIX % WORD_W);

  state_t            r_state;
  logic [7:0]        r_rule;
  logic              r_dir;
  logic [IDX_W-1:0]  r_ridx;
  logic [IDX_W-1:0]  r_widx;
  logic              r_left;
  logic              r_first;
  logic [WORD_W-1:0] r_cur;

  logic              w_edge_left;
  logic              w_edge_first;
  logic              w_right;
  logic [IDX_W-1:0]  w_ridx_nxt;
  logic [WORD_W-1:0] w_next;

`ifdef CA_WRAP_EN
  assign w_edge_left  = rdata[WORD_W-1];
  assign w_edge_first = rdata[0];
`else
  assign w_edge_left  = 1'b0;
  assign w_edge_first = 1'b0;
`endif

  // last word takes its right neighbour from the saved first bit, others from the word just read
  assign w_right    = (r_state == S_FLUSH) ? r_first : rdata[0];
  assign w_ridx_nxt = r_ridx + 1'b1;

  ca_rule_word #(.WORD_W(WORD_W)) u_rule (
    .i_left  (r_left),
    .i_word  (r_cur),
    .i_right (w_right),
    .i_rule  (r_rule),
    .o_word  (w_next)
  );

  function automatic logic [WORD_W-1:0] seed_word(input logic [IDX_W-1:0] idx);
    return (idx == SEED_IDX) ? SEED_BIT : '0;
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_rule  <= '0;
      r_dir   <= 1'b0;
      r_ridx  <= '0;
      r_widx  <= '0;
      r_left  <= 1'b0;
      r_first <= 1'b0;
      r_cur   <= '0;
      read    <= 1'b0;
      raddr   <= '0;
      write   <= 1'b0;
      waddr   <= '0;
      wdata   <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_rule <= rule;
            r_dir  <= direction;
            busy   <= 1'b1;
            if (mode == MODE_SEED) begin
              write   <= 1'b1;
              waddr   <= {~direction, IDX_W'(0)};
              wdata   <= seed_word('0);
              r_widx  <= IDX_W'(1);
              r_state <= S_SEED;
            end else begin
              read    <= 1'b1;
              raddr   <= {direction, LAST_IDX};
              r_ridx  <= LAST_IDX;
              r_widx  <= '0;
              r_state <= S_PREFETCH;
            end
          end
        end
        S_PREFETCH: begin
          r_left  <= w_edge_left;
          r_ridx  <= w_ridx_nxt;
          raddr   <= {r_dir, w_ridx_nxt};
          r_state <= S_STREAM;
        end
        S_STREAM: begin
          r_cur <= rdata;
          if (r_ridx == '0) begin
            r_first <= w_edge_first;
          end else begin
            write  <= 1'b1;
            waddr  <= {~r_dir, r_widx};
            wdata  <= w_next;
            r_widx <= r_widx + 1'b1;
            r_left <= r_cur[WORD_W-1];
          end
          if (r_ridx == LAST_IDX) begin
            read    <= 1'b0;
            r_state <= S_FLUSH;
          end else begin
            r_ridx <= w_ridx_nxt;
            raddr  <= {r_dir, w_ridx_nxt};
          end
        end
        S_FLUSH: begin
          waddr   <= {~r_dir, r_widx};
          wdata   <= w_next;
          r_state <= S_FIN;
        end
        S_SEED: begin
          waddr  <= {~r_dir, r_widx};
          wdata  <= seed_word(r_widx);
          r_widx <= r_widx + 1'b1;
          if (r_widx == LAST_IDX) r_state <= S_FIN;
        end
        S_FIN: begin
          write   <= 1'b0;
          busy    <= 1'b0;
          done    <= 1'b1;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ca_line_gen.sv
// tb/tb_ca_line_gen.sv - directed self-checking bench for ca_line_gen with a dual-port line RAM model
module tb_ca_line_gen;
  import ca_pkg::*;

  localparam int W  = 16;
  localparam int LW = 4;
  localparam int AW = 3;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic          mode = 1'b0;
  logic [7:0]    rule = 8'h00;
  logic          direction = 1'b0;
  logic          read;
  logic [AW-1:0] raddr;
  logic [W-1:0]  rdata;
  logic          write;
  logic [AW-1:0] waddr;
  logic [W-1:0]  wdata;
  logic          busy;
  logic          done;

  logic [W-1:0]  mem [0:7];
  logic          pl_en = 1'b0;
  logic [AW-1:0] pl_addr = '0;
  logic [W-1:0]  pl_data = '0;

  int checks = 0;
  int errors = 0;
  int n_wr = 0;
  int n_done = 0;

  ca_line_gen #(.WORD_W(W), .LINE_WORDS(LW), .ADDR_W(AW)) dut (
    .clk(clk), .rst(rst), .start(start), .mode(mode), .rule(rule),
    .direction(direction), .read(read), .raddr(raddr), .rdata(rdata),
    .write(write), .waddr(waddr), .wdata(wdata), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  assign rdata = read ? mem[raddr] : 16'hDEAD;

  always @(posedge clk) begin
    if (write) begin
      mem[waddr] <= wdata;
      n_wr <= n_wr + 1;
    end else if (pl_en) begin
      mem[pl_addr] <= pl_data;
    end
    if (done) n_done <= n_done + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // inputs are scrambled after the start cycle so latching is exercised
  task automatic go(input logic m, input logic [7:0] r, input logic d);
    mode = m; rule = r; direction = d; start = 1'b1;
    cyc();
    start = 1'b0; mode = ~m; rule = ~r; direction = ~d;
  endtask

  task automatic preload(input logic [AW-1:0] a, input logic [W-1:0] d);
    pl_en = 1'b1; pl_addr = a; pl_data = d;
    cyc();
    pl_en = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    for (int i = 0; i < 40; i++) begin
      if (done) break;
      cyc();
    end
    chk(tag, done, 1);
  endtask

  initial begin
    logic [W-1:0]  seed_exp [4];
    logic [AW-1:0] ev_ra [5];
    logic [W-1:0]  ev_wd [4];
    logic [W-1:0]  wrap_exp [4];
    logic [W-1:0]  r30_exp [4];
    int w0;
    int d0;
    int w1;

    seed_exp = '{16'h0000, 16'h0000, 16'h0001, 16'h0000};
    ev_ra    = '{3'd7, 3'd4, 3'd5, 3'd6, 3'd7};
    ev_wd    = '{16'h0000, 16'h8000, 16'h0002, 16'h0000};
`ifdef CA_WRAP_EN
    wrap_exp = '{16'h0002, 16'h0000, 16'h0000, 16'h8000};
    r30_exp  = '{16'h0000, 16'h0000, 16'h0000, 16'h0000};
`else
    wrap_exp = '{16'h0002, 16'h0000, 16'h0000, 16'h0000};
    r30_exp  = '{16'h0001, 16'h0000, 16'h0000, 16'h0000};
`endif

    cyc();
    cyc();
    chk("rst_read", read, 0);
    chk("rst_raddr", raddr, 0);
    chk("rst_write", write, 0);
    chk("rst_waddr", waddr, 0);
    chk("rst_wdata", wdata, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    rst = 1'b0;
    cyc();

    // seed into bank 1
    go(MODE_SEED, 8'h00, 1'b0);
    for (int c = 1; c <= 5; c++) begin
      chk($sformatf("seed_read_%0d", c), read, 0);
      chk($sformatf("seed_write_%0d", c), write, (c <= 4) ? 1 : 0);
      if (c <= 4) begin
        chk($sformatf("seed_waddr_%0d", c), waddr, 4 + c - 1);
        chk($sformatf("seed_wdata_%0d", c), wdata, seed_exp[c-1]);
      end
      chk($sformatf("seed_done_%0d", c), done, (c == 5) ? 1 : 0);
      cyc();
    end
    chk("seed_done_clear", done, 0);

    // rule 90 from bank 1 into bank 0, cycle-exact
    go(MODE_EVOLVE, RULE_90, 1'b1);
    for (int c = 1; c <= 8; c++) begin
      chk($sformatf("ev_read_%0d", c), read, (c <= 5) ? 1 : 0);
      if (c <= 5) chk($sformatf("ev_raddr_%0d", c), raddr, ev_ra[c-1]);
      chk($sformatf("ev_write_%0d", c), write, (c >= 4 && c <= 7) ? 1 : 0);
      if (c >= 4 && c <= 7) begin
        chk($sformatf("ev_waddr_%0d", c), waddr, c - 4);
        chk($sformatf("ev_wdata_%0d", c), wdata, ev_wd[c-4]);
      end
      chk($sformatf("ev_busy_%0d", c), busy, (c <= 7) ? 1 : 0);
      chk($sformatf("ev_done_%0d", c), done, (c == 8) ? 1 : 0);
      cyc();
    end

    // edge behaviour: pixel 0 set, rule 90, bank 0 into bank 1
    preload(3'd0, 16'h0001);
    preload(3'd1, 16'h0000);
    preload(3'd2, 16'h0000);
    preload(3'd3, 16'h0000);
    go(MODE_EVOLVE, RULE_90, 1'b0);
    wait_done("wrap_done");
    for (int k = 0; k < 4; k++) chk($sformatf("wrap_word_%0d", k), mem[4+k], wrap_exp[k]);
    cyc();

    go(MODE_EVOLVE, 8'd0, 1'b1);
    wait_done("r0_done");
    for (int k = 0; k < 4; k++) chk($sformatf("r0_word_%0d", k), mem[k], 16'h0000);
    cyc();

    go(MODE_EVOLVE, 8'd255, 1'b0);
    wait_done("r255_done");
    for (int k = 0; k < 4; k++) chk($sformatf("r255_word_%0d", k), mem[4+k], 16'hFFFF);
    cyc();

    // rule 30 on an all-ones line, second start at T+3 must be ignored
    w0 = n_wr;
    d0 = n_done;
    go(MODE_EVOLVE, RULE_30, 1'b1);
    cyc();
    cyc();
    start = 1'b1;
    mode = MODE_SEED;
    cyc();
    start = 1'b0;
    for (int i = 0; i < 12; i++) cyc();
    chk("dbl_writes", n_wr - w0, 4);
    chk("dbl_dones", n_done - d0, 1);
    chk("dbl_busy", busy, 0);
    for (int k = 0; k < 4; k++) chk($sformatf("r30_word_%0d", k), mem[k], r30_exp[k]);

    // reset in the middle of an evolve run
    go(MODE_EVOLVE, RULE_90, 1'b0);
    w0 = n_wr;
    cyc();
    cyc();
    cyc();
    cyc();
    chk("abort_pre_write", write, 1);
    rst = 1'b1;
    #1;
    chk("abort_read", read, 0);
    chk("abort_write", write, 0);
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    cyc();
    cyc();
    chk("abort_writes_before", n_wr - w0, 1);
    rst = 1'b0;
    w1 = n_wr;
    for (int i = 0; i < 10; i++) cyc();
    chk("abort_no_writes", n_wr - w1, 0);
    chk("abort_idle_busy", busy, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
